// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width and the decoded control
// bundle carried from Decode into Execute.
package riscv_pkg;

    localparam int XLEN = 32;

    // Decoded control bundle; field order matches the controller output.
    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_e_t;

    // A bubble performs no architectural side effect: every control bit is 0.
    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/flopenrc.sv
// Generic register with asynchronous reset, enable and synchronous clear.
// Clear takes priority over enable, so a clear is honoured even while held.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register: reset > clear > enabled load > hold.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its inputs from before the edge, independent of block order.
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_pipereg.sv
// ID/EX pipeline register. Captures the decoded control bundle, valid bit and
// datapath operands of the Decode-stage instruction for the Execute stage.
// StallE holds the slot, FlushE inserts a bubble (flush beats stall).
// Optional feature macro: ID_EX_PERF_EN adds the 32-bit BubbleCountE counter.
module id_ex_pipereg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     BubbleCountE
`endif
);

    localparam int CTRL_W = $bits(ctrl_e_t) + 1;
    localparam int DATA_W = 5 * XLEN + 3 * 5;

    ctrl_e_t           w_ctrl_d;
    ctrl_e_t           w_ctrl_e;
    logic [CTRL_W-1:0] w_cv_e;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_e;
    logic              w_en;

    assign w_en = ~StallE;

    assign w_ctrl_d = '{
        RegWrite:   RegWriteD,
        ResultSrc:  ResultSrcD,
        MemWrite:   MemWriteD,
        Jump:       JumpD,
        Branch:     BranchD,
        ALUControl: ALUControlD,
        ALUSrc:     ALUSrcD
    };

    assign w_data_d = {RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD};

    // Control bundle plus valid bit. Clearing to zero yields CTRL_BUBBLE with
    // ValidE=0, which is exactly the bubble encoding.
    flopenrc #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (FlushE),
        .d     ({w_ctrl_d, ValidD}),
        .q     (w_cv_e)
    );

    // Datapath operands and register indices; a bubble carries RdE=0 so the
    // forwarding unit can never match it.
    flopenrc #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (FlushE),
        .d     (w_data_d),
        .q     (w_data_e)
    );

    assign {w_ctrl_e, ValidE} = w_cv_e;

    assign RegWriteE   = w_ctrl_e.RegWrite;
    assign ResultSrcE  = w_ctrl_e.ResultSrc;
    assign MemWriteE   = w_ctrl_e.MemWrite;
    assign JumpE       = w_ctrl_e.Jump;
    assign BranchE     = w_ctrl_e.Branch;
    assign ALUControlE = w_ctrl_e.ALUControl;
    assign ALUSrcE     = w_ctrl_e.ALUSrc;

    assign {RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE} = w_data_e;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_count;
    logic        w_bubble_loaded;

    // A bubble is loaded on a flush, or on an unstalled load of an invalid
    // D-stage slot. Held (stalled) slots are not new bubbles.
    assign w_bubble_loaded = FlushE | (~StallE & ~ValidD);

    // Bubble counter; wraps silently at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bubble_count <= '0;
        else if (w_bubble_loaded)
            r_bubble_count <= r_bubble_count + 32'd1;
    end

    assign BubbleCountE = r_bubble_count;
`endif

endmodule
